// File: rtl/hdmi_pkg.sv
// Shared constants and types for the HDMI audio sample packet path.
package hdmi_pkg;

    localparam logic [7:0]     HB0_AUDIO    = 8'h02;
    localparam int unsigned    IEC_FRAMES   = 192;
    localparam logic [191:0]   CS_L_DEFAULT = 192'h0202100004;
    localparam logic [191:0]   CS_R_DEFAULT = 192'h0202200004;

    // Subpacket layout: {Pr,Cr,Ur,Vr, Pl,Cl,Ul,Vl, R24, L24}
    localparam int unsigned    SUB_W     = 56;
    localparam int unsigned    SUB_L_LSB = 0;
    localparam int unsigned    SUB_R_LSB = 24;
    localparam int unsigned    SUB_VL    = 48;
    localparam int unsigned    SUB_UL    = 49;
    localparam int unsigned    SUB_CL    = 50;
    localparam int unsigned    SUB_PL    = 51;
    localparam int unsigned    SUB_VR    = 52;
    localparam int unsigned    SUB_UR    = 53;
    localparam int unsigned    SUB_CR    = 54;
    localparam int unsigned    SUB_PR    = 55;

    typedef enum logic [1:0] {
        StIdle,
        StBuild,
        StDone
    } pkt_state_e;

    function automatic logic [23:0] left_justify(input logic [23:0] s, input int unsigned w);
        return s << (24 - w);
    endfunction

endpackage

// File: rtl/hdmi_audio_subpkt.sv
// Combinational formatter: one stereo sample plus frame index into a 56-bit subpacket.
module hdmi_audio_subpkt
    import hdmi_pkg::*;
#(
    parameter int unsigned  SAMPLE_W = 16,
    parameter logic [191:0] CS_L     = CS_L_DEFAULT,
    parameter logic [191:0] CS_R     = CS_R_DEFAULT
) (
    input  logic [SAMPLE_W-1:0] lsample,
    input  logic [SAMPLE_W-1:0] rsample,
    input  logic [7:0]          csb,
    output logic [SUB_W-1:0]    subpkt
);

    logic [23:0] l24;
    logic [23:0] r24;
    logic        cl;
    logic        cr;

    always_comb begin
        l24 = left_justify(24'(lsample), SAMPLE_W);
        r24 = left_justify(24'(rsample), SAMPLE_W);
        cl  = CS_L[csb];
        cr  = CS_R[csb];

        // U and V are always zero, so parity covers only the sample and C.
        subpkt                     = '0;
        subpkt[SUB_L_LSB +: 24]    = l24;
        subpkt[SUB_R_LSB +: 24]    = r24;
        subpkt[SUB_VL]             = 1'b0;
        subpkt[SUB_UL]             = 1'b0;
        subpkt[SUB_CL]             = cl;
        subpkt[SUB_PL]             = (^l24) ^ cl;
        subpkt[SUB_VR]             = 1'b0;
        subpkt[SUB_UR]             = 1'b0;
        subpkt[SUB_CR]             = cr;
        subpkt[SUB_PR]             = (^r24) ^ cr;
    end

endmodule

// File: rtl/hdmi_audio_packetizer.sv
// Stereo PCM FIFO plus packet builder producing HDMI Audio Sample Packets on request.
module hdmi_audio_packetizer
    import hdmi_pkg::*;
#(
    parameter int unsigned  DEPTH    = 8,
    parameter int unsigned  SAMPLE_W = 16,
    parameter int unsigned  SP       = 2,
    parameter logic [191:0] CS_L     = CS_L_DEFAULT,
    parameter logic [191:0] CS_R     = CS_R_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [2*SAMPLE_W-1:0]     in_data,
    input  logic                      flush,
    input  logic                      pkt_req,
    output logic                      pkt_valid,
    output logic [23:0]               pkt_hdr,
    output logic [SUB_W*SP-1:0]       pkt_sub,
    output logic [$clog2(DEPTH):0]    level
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;
    localparam int unsigned DW = 2 * SAMPLE_W;

    logic [DW-1:0]       mem [DEPTH];
    logic [PW-1:0]       wptr_q, wptr_d;
    logic [PW-1:0]       rptr_q, rptr_d;
    logic [LW-1:0]       level_q, level_d;
    logic [7:0]          csb_q, csb_d;
    pkt_state_e          state_q, state_d;
    logic [2:0]          slot_q, slot_d;
    logic [3:0]          present_q, present_d;
    logic [3:0]          bflag_q, bflag_d;
    logic [SUB_W*SP-1:0] stage_q, stage_d;
    logic [23:0]         hdr_q, hdr_d;
    logic [SUB_W*SP-1:0] sub_q, sub_d;
    logic                valid_q, valid_d;

    logic                push;
    logic                pop;
    logic [DW-1:0]       head;
    logic [SUB_W-1:0]    slot_sub;

    assign in_ready  = (level_q != LW'(DEPTH));
    assign push      = in_valid && in_ready && !flush;
    assign pop       = (state_q == StBuild) && (level_q != '0) && !flush;
    assign head      = mem[rptr_q];

    assign pkt_valid = valid_q;
    assign pkt_hdr   = hdr_q;
    assign pkt_sub   = sub_q;
    assign level     = level_q;

    hdmi_audio_subpkt #(
        .SAMPLE_W (SAMPLE_W),
        .CS_L     (CS_L),
        .CS_R     (CS_R)
    ) u_subpkt (
        .lsample (head[SAMPLE_W-1:0]),
        .rsample (head[DW-1:SAMPLE_W]),
        .csb     (csb_q),
        .subpkt  (slot_sub)
    );

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr_q] <= in_data;
        end
    end

    always_comb begin
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        level_d   = level_q;
        csb_d     = csb_q;
        state_d   = state_q;
        slot_d    = slot_q;
        present_d = present_q;
        bflag_d   = bflag_q;
        stage_d   = stage_q;
        hdr_d     = hdr_q;
        sub_d     = sub_q;
        valid_d   = 1'b0;

        if (push) begin
            wptr_d = wptr_q + PW'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + PW'(1);
            csb_d  = (csb_q == 8'(IEC_FRAMES - 1)) ? 8'd0 : csb_q + 8'd1;
        end
        unique case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        unique case (state_q)
            StIdle: begin
                if (pkt_req) begin
                    state_d   = StBuild;
                    slot_d    = 3'd0;
                    present_d = 4'd0;
                    bflag_d   = 4'd0;
                    stage_d   = '0;
                end
            end
            StBuild: begin
                if (pop) begin
                    for (int k = 0; k < int'(SP); k++) begin
                        if (slot_q == 3'(k)) begin
                            stage_d[k*SUB_W +: SUB_W] = slot_sub;
                            present_d[k]              = 1'b1;
                            bflag_d[k]                = (csb_q == 8'd0);
                        end
                    end
                end
                slot_d = slot_q + 3'd1;
                // Outputs are loaded on entry to DONE so pkt_valid lands in the DONE cycle.
                if (slot_q == 3'(SP - 1)) begin
                    state_d = StDone;
                    valid_d = 1'b1;
                    hdr_d   = {bflag_d, 4'h0, 4'h0, present_d,
                               (present_d != 4'd0) ? HB0_AUDIO : 8'h00};
                    sub_d   = stage_d;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            level_d = '0;
            csb_d   = 8'd0;
            state_d = StIdle;
            valid_d = 1'b0;
            hdr_d   = hdr_q;
            sub_d   = sub_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            level_q   <= '0;
            csb_q     <= 8'd0;
            state_q   <= StIdle;
            slot_q    <= 3'd0;
            present_q <= 4'd0;
            bflag_q   <= 4'd0;
            stage_q   <= '0;
            hdr_q     <= '0;
            sub_q     <= '0;
            valid_q   <= 1'b0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            level_q   <= level_d;
            csb_q     <= csb_d;
            state_q   <= state_d;
            slot_q    <= slot_d;
            present_q <= present_d;
            bflag_q   <= bflag_d;
            stage_q   <= stage_d;
            hdr_q     <= hdr_d;
            sub_q     <= sub_d;
            valid_q   <= valid_d;
        end
    end

endmodule

// File: tb/tb_hdmi_audio_packetizer.sv
// Directed bench for the audio packetizer: default build plus a 24-bit, 4-subpacket build.
module tb_hdmi_audio_packetizer;

    localparam int unsigned SP_A = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         in_valid, in_ready, flush, pkt_req, pkt_valid;
    logic [31:0]  in_data;
    logic [23:0]  pkt_hdr;
    logic [111:0] pkt_sub;
    logic [3:0]   level;

    logic         b_in_valid, b_in_ready, b_pkt_req, b_pkt_valid;
    logic [47:0]  b_in_data;
    logic [23:0]  b_pkt_hdr;
    logic [223:0] b_pkt_sub;
    logic [2:0]   b_level;

    hdmi_audio_packetizer #(
        .DEPTH    (8),
        .SAMPLE_W (16),
        .SP       (SP_A)
    ) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .flush     (flush),
        .pkt_req   (pkt_req),
        .pkt_valid (pkt_valid),
        .pkt_hdr   (pkt_hdr),
        .pkt_sub   (pkt_sub),
        .level     (level)
    );

    hdmi_audio_packetizer #(
        .DEPTH    (4),
        .SAMPLE_W (24),
        .SP       (4)
    ) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_in_data),
        .flush     (flush),
        .pkt_req   (b_pkt_req),
        .pkt_valid (b_pkt_valid),
        .pkt_hdr   (b_pkt_hdr),
        .pkt_sub   (b_pkt_sub),
        .level     (b_level)
    );

    int checks = 0;
    int errors = 0;

    logic [191:0] cs_l = 192'h0202100004;
    logic [191:0] cs_r = 192'h0202200004;
    logic [31:0]  q[$];
    int           exp_csb = 0;
    int           bcount = 0;
    logic [23:0]  last_hdr;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [55:0] mk_sub(input logic [31:0] s, input int csb);
        logic [23:0] l24, r24;
        logic        cl, cr;
        l24 = {s[15:0], 8'h00};
        r24 = {s[31:16], 8'h00};
        cl  = cs_l[csb];
        cr  = cs_r[csb];
        return {(^r24) ^ cr, cr, 2'b00, (^l24) ^ cl, cl, 2'b00, r24, l24};
    endfunction

    task automatic push_a(input logic [15:0] l, input logic [15:0] r);
        in_valid = 1'b1;
        in_data  = {r, l};
        tick();
        in_valid = 1'b0;
        q.push_back({r, l});
    endtask

    task automatic do_pkt(input string tag);
        logic [111:0] es;
        logic [3:0]   p, b;
        logic [23:0]  eh;
        int           n;
        es = '0;
        p  = 4'd0;
        b  = 4'd0;
        for (int k = 0; k < int'(SP_A); k++) begin
            if (q.size() > 0) begin
                es[k*56 +: 56] = mk_sub(q[0], exp_csb);
                void'(q.pop_front());
                p[k] = 1'b1;
                b[k] = (exp_csb == 0);
                if (exp_csb == 0) bcount++;
                exp_csb = (exp_csb + 1) % 192;
            end
        end
        eh = {b, 4'h0, 4'h0, p, (p != 4'd0) ? 8'h02 : 8'h00};
        last_hdr = eh;
        pkt_req = 1'b1;
        tick();
        pkt_req = 1'b0;
        n = 1;
        while (!pkt_valid && n < 10) begin
            tick();
            n++;
        end
        check({tag, " latency"}, n, SP_A + 1);
        check({tag, " hdr"}, pkt_hdr, eh);
        check({tag, " sub"}, pkt_sub, es);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int pulses;
        in_valid   = 1'b0;
        in_data    = '0;
        flush      = 1'b0;
        pkt_req    = 1'b0;
        b_in_valid = 1'b0;
        b_in_data  = '0;
        b_pkt_req  = 1'b0;

        #12;
        check("reset valid", pkt_valid, 0);
        check("reset hdr", pkt_hdr, 0);
        check("reset sub", pkt_sub, 0);
        check("reset level", level, 0);
        check("reset ready", in_ready, 1);
        rst_n = 1'b1;
        tick();

        do_pkt("empty");

        push_a(16'h1234, 16'h5678);
        check("push level", level, 1);
        do_pkt("first");
        check("first hand hdr", pkt_hdr, 24'h100102);
        check("first hand sub", pkt_sub, {56'h0, 56'h08_567800_123400});

        // Full FIFO: ninth sample must wait until a pop frees a slot.
        for (int i = 0; i < 8; i++) push_a(16'(16'h0100 + i), 16'(16'h0200 + i));
        check("full level", level, 8);
        check("full ready", in_ready, 0);
        in_valid = 1'b1;
        in_data  = {16'h0208, 16'h0108};
        tick();
        check("full hold level", level, 8);
        pkt_req = 1'b1;
        tick();
        pkt_req = 1'b0;
        check("full slot0 level", level, 8);
        tick();
        check("full pop level", level, 7);
        check("full pop ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("full push level", level, 7);
        check("full valid", pkt_valid, 1);
        check("full hdr", pkt_hdr, 24'h000302);
        check("full sub", pkt_sub, {56'hCC_020100_010100, 56'h88_020000_010000});
        void'(q.pop_front());
        void'(q.pop_front());
        exp_csb = 3;
        q.push_back({16'h0208, 16'h0108});
        tick();
        for (int i = 0; i < 4; i++) do_pkt("drain");
        check("drain level", level, 0);

        // 24-bit, 4-subpacket build with three samples queued.
        b_in_valid = 1'b1;
        b_in_data  = {24'h123456, 24'hABCDEF};
        tick();
        b_in_data  = {24'h800000, 24'h000001};
        tick();
        b_in_data  = {24'h000000, 24'hFFFFFF};
        tick();
        b_in_valid = 1'b0;
        check("wide level", b_level, 3);
        b_pkt_req = 1'b1;
        tick();
        b_pkt_req = 1'b0;
        n = 1;
        while (!b_pkt_valid && n < 12) begin
            tick();
            n++;
        end
        check("wide latency", n, 5);
        check("wide hdr", b_pkt_hdr, 24'h100702);
        check("wide sub", b_pkt_sub, {56'h0, 56'hCC_000000_FFFFFF, 56'h88_800000_000001,
                                      56'h88_123456_ABCDEF});
        tick();

        // csb wrap across 200 samples, starting from a flushed state.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        q.delete();
        exp_csb = 0;
        bcount  = 0;
        for (int i = 0; i < 100; i++) begin
            push_a(16'(16'h3000 + 2 * i), 16'(16'h7000 - 2 * i));
            push_a(16'(16'h3001 + 2 * i), 16'(16'h6FFF - 2 * i));
            do_pkt("wrap");
        end
        check("wrap bflags", bcount, 2);

        // Flush in BUILD slot 1 with level 3.
        for (int i = 0; i < 4; i++) push_a(16'(16'h0A00 + i), 16'(16'h0B00 + i));
        pkt_req = 1'b1;
        tick();
        pkt_req = 1'b0;
        tick();
        check("flush pre level", level, 3);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush valid", pkt_valid, 0);
        check("flush level", level, 0);
        check("flush hdr kept", pkt_hdr, last_hdr);
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (pkt_valid) pulses++;
        end
        check("flush no pkt", pulses, 0);
        q.delete();
        exp_csb = 0;
        push_a(16'hBEEF, 16'hCAFE);
        do_pkt("post flush");
        check("post flush b", pkt_hdr[23:16], 8'h10);

        // A second request during BUILD must not start another packet.
        push_a(16'h1111, 16'h2222);
        pkt_req = 1'b1;
        tick();
        tick();
        pkt_req = 1'b0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (pkt_valid) pulses++;
        end
        check("req ignored", pulses, 1);

        // Reset in the middle of BUILD.
        push_a(16'h4444, 16'h5555);
        push_a(16'h6666, 16'h7777);
        pkt_req = 1'b1;
        tick();
        pkt_req = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        check("midrst valid", pkt_valid, 0);
        check("midrst level", level, 0);
        check("midrst hdr", pkt_hdr, 0);
        check("midrst sub", pkt_sub, 0);
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (pkt_valid) pulses++;
        end
        check("midrst no pkt", pulses, 0);
        rst_n = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hdmi_audio_packetizer.md
# hdmi_audio_packetizer

Parametrised audio front end for the HDMI data-island path. Buffers stereo PCM samples in a DEPTH-entry FIFO and, on request, assembles one HDMI Audio Sample Packet: a 24-bit header plus SP 56-bit subpackets. Each subpacket carries IEC 60958 channel-status bits, parity and B flags. The result feeds the BCH/TERC4 serializer and replaces the fixed two-sample buffer, adding configurable depth, sample width and subpacket count.

## Interface
- DEPTH, 8: FIFO entries; power of two, ≥2.
- SAMPLE_W, 16: bits per channel sample, 16..24.
- SP, 2: subpackets per packet, 1..4.
- CS_L, 192'h…0202100004: left channel-status block; bit n is sent in frame n.
- CS_R, 192'h…0202200004: right channel-status block.
- clk  in  1  clock; one clock, all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  sample offered.
- in_ready  out  1  FIFO can accept.
- in_data  in  2*SAMPLE_W  {right, left}.
- flush  in  1  synchronous clear.
- pkt_req  in  1  one-cycle request for a packet.
- pkt_valid  out  1  one-cycle strobe; packet outputs valid.
- pkt_hdr  out  24  {HB2, HB1, HB0}.
- pkt_sub  out  56*SP  subpacket k in bits [56k+55:56k].
- level  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- **FIFO**
  - Circular buffer with read and write pointers and a level counter.
  - in_ready = (level != DEPTH). There is no same-cycle pass-through, so a full FIFO refuses input even in a pop cycle.
  - A push and a pop in the same cycle leave level unchanged.
- **FSM states:** IDLE, BUILD, DONE.
  - IDLE → BUILD on pkt_req. Slot index k is set to 0 and the staging header is cleared.
  - pkt_req is ignored outside IDLE.
- **BUILD, slot k, one cycle per slot**
  - If level > 0: pop one sample. Write the formatted subpacket to slot k, set HB1[k]=1, set HB2[4+k]=(csb==0), then advance csb (191 → 0).
  - If level = 0: slot k = 0, and HB1[k], HB2[4+k] and csb are unchanged.
  - After slot SP−1 go to DONE.
- **DONE**
  - Copy the staging registers to pkt_hdr/pkt_sub and pulse pkt_valid.
  - HB0 = 8'h02 if any sample is present, else 8'h00.
  - Return to IDLE.
  - Outputs hold until the next DONE.
- **Subpacket format:** {Pr,Cr,Ur,Vr, Pl,Cl,Ul,Vl, R24, L24}.
  - Sample s is left-justified: R24 = {s, (24−SAMPLE_W) zeros}.
  - U = V = 0. C = CS_x[csb] for the slot's frame.
  - P = XOR over {R24/L24, C, U, V}, giving even parity.
- **HB1/HB2 packing:** HB1[7:4] = 0 (layout 0). HB2[3:0] = 0.
- **flush**
  - Zeroes the pointers, level and csb.
  - Forces IDLE, aborting any packet in progress with no pkt_valid.
  - A push in the flush cycle is dropped.
  - Packet outputs are kept.

## Timing
- **Reset values:**
  - pkt_valid = 0, pkt_hdr = 0, pkt_sub = 0, level = 0, csb = 0, state IDLE.
  - in_ready = 1 once reset is released (level 0).
- **Latency:** pkt_req in cycle t gives pkt_valid in cycle t+SP+1.
- **Push timing:** a sample pushed in cycle t is poppable from t+1 and counted in level at t+1.
- **csb wrap:** csb wraps 191 → 0 between consecutive samples, including across packets. The sample taken at csb=0 carries B=1.
- **Reset mid-operation:** rst_n asserted during BUILD returns everything to reset values immediately; no partial packet is emitted.

## Structure
- **Shared package `hdmi_pkg`:**
  - HB0_AUDIO = 8'h02.
  - IEC_FRAMES = 192.
  - Default CS_L/CS_R constants.
  - Subpacket bit-offset localparams.
- **Sub-module `hdmi_audio_subpkt`:** combinational formatter, (lsample, rsample, csb) → 56-bit subpacket. It is instantiated once and time-shared across BUILD slots.
- **Top level:** the FIFO and FSM live in this block.

## Test plan
- **Reset:** apply reset, then push L=16'h1234, R=16'h5678 and pulse pkt_req with SP=2 → pkt_valid at t+3, HB0=02, HB1=01, HB2=10, L24=123400, R24=567800, parities correct.
- **Empty request:** pulse pkt_req with the FIFO empty → pkt_hdr=000000, pkt_sub=0, csb stays 0.
- **Full FIFO:** push 9 samples with DEPTH=8 → in_ready drops after the 8th, level=8, and the 9th is held until a pop frees a slot.
- **csb wrap:** stream 200 samples via repeated packets → B=1 only on samples 0 and 192, and Cl follows CS_L (bit 2 = 1 on frame 2).
- **Mid-build events:**
  - flush asserted in BUILD slot 1 with level=3 → no pkt_valid, level=0, next packet's first sample has B=1.
  - pkt_req during BUILD is ignored.
- **Extreme parameters:** SAMPLE_W=24, SP=4 with 3 samples queued → HB1=07, slot 3 zero, full 24-bit samples unshifted, parity over 27 bits.
